sprite_frame_buffer: RTL and testbench
======================================

// Module: sprite_frame_buffer
// PURPOSE
// - Double-buffered sprite position store between the physics engine and VGA_driver.
// - The physics side writes a batch of per-sprite row/col updates into shadow registers using a valid/ready handshake.
// - The completed batch is committed to the active outputs on the frame_start pulse, so the display never tears mid-frame.
// - The active outputs drive VGA_driver sprite_row/sprite_col directly.
// PARAMETERS
// - SPRITES  default 4     number of sprites; range 1..16
// - IDX_W    default 2     wr_index width = $clog2(SPRITES), minimum 1
// - MAX_ROW  default 1199  largest legal visible row
// - MAX_COL  default 1599  largest legal visible column
// PORTS
// - clock_162     in   1             pixel clock; single clock domain
// - rst           in   1             synchronous, active-high reset
// - frame_start   in   1             1-cycle pulse at start of vertical blanking
// - wr_valid      in   1             update beat valid
// - wr_ready      out  1             block accepts a beat; transfer = wr_valid & wr_ready
// - wr_index      in   IDX_W         sprite number
// - wr_row        in   11            new row
// - wr_col        in   12            new column
// - wr_last       in   1             beat closes the batch
// - sprite_row    out  [SPRITES-1:0][10:0]  active rows, registered
// - sprite_col    out  [SPRITES-1:0][11:0]  active columns, registered
// - commit_pulse  out  1             high for 1 cycle when the active set updates
// - frame_count   out  16            commits since reset; wraps 0xFFFF->0
// - idx_err       out  1             sticky; set by an accepted beat with wr_index >= SPRITES
// - stale_frames  out  16            see CONFIGURATION
// BEHAVIOUR
// - Reset values
//   - All shadow and active rows/cols = 0.
//   - State = IDLE; wr_ready = 1; commit_pulse = 0.
//   - frame_count = 0; idx_err = 0; stale_frames = 0.
// - FSM states: IDLE, PENDING, COMMIT.
//   - IDLE: wr_ready = 1.
//     - Each accepted beat writes shadow[wr_index] on the same edge.
//     - An accepted beat with wr_last = 1 moves the FSM to PENDING.
//     - frame_start in IDLE is ignored for commit; a partial batch is never shown.
//   - PENDING: wr_ready = 0.
//     - On frame_start at edge N: active <= shadow, state -> COMMIT.
//   - COMMIT (one cycle, N+1):
//     - New positions are visible and commit_pulse = 1.
//     - wr_ready = 0; frame_count increments.
//     - State -> IDLE; wr_ready = 1 from N+2.
// - Latency: frame_start to new outputs = 1 cycle.
// - Shadow is not cleared after a commit. Unwritten sprites keep their last value.
// - Clamping at shadow write:
//   - wr_row > MAX_ROW stores MAX_ROW.
//   - wr_col > MAX_COL stores MAX_COL.
//   - Compares are unsigned, full-width.
// - wr_index >= SPRITES: the beat completes the handshake and sets idx_err. No shadow write.
//   - If wr_last = 1 on that beat, the batch still closes.
// - frame_start in the same cycle as an accepted wr_last in IDLE:
//   - Goes to PENDING; the commit happens at the next frame_start.
// - Two beats to the same index in one batch: the later beat wins.
// - rst mid-batch or in PENDING/COMMIT: all state returns to reset values on that edge. The pending batch is discarded.
// CONFIGURATION
// - Macro SPRITE_FRAME_STALE_CNT_EN.
// - Defined:
//   - stale_frames increments on each frame_start seen in IDLE (no batch ready).
//   - Saturates at 0xFFFF; cleared only by rst.
// - Undefined: stale_frames is tied to 0 and no counter logic is built.
// TESTING
// - Reset, then 3 idle cycles -> all outputs 0, wr_ready = 1, no commit_pulse.
// - Batch of idx0 (row 100, col 200) and idx1 (row 300, col 400, last), then frame_start 10 cycles later:
//   - Outputs stay 0 until frame_start+1.
//   - At frame_start+1: sprite 0 = (100,200), sprite 1 = (300,400), commit_pulse = 1, frame_count = 1.
// - In PENDING, drive wr_valid = 1 for 5 cycles:
//   - wr_ready = 0 throughout; shadow is unchanged.
//   - After frame_start, wr_ready = 1 two cycles later.
// - Write row 1500, col 4000 (last), then commit -> row 1199, col 1599.
// - Write idx 5 with SPRITES = 4 and wr_last = 1 -> idx_err = 1, no position changes, FSM -> PENDING.
// - frame_start in the same cycle as wr_last:
//   - No commit on that frame.
//   - Commit on the next frame_start.
//   - With SPRITE_FRAME_STALE_CNT_EN defined: stale_frames stays 0.
// - frame_start x3 with no batch and SPRITE_FRAME_STALE_CNT_EN defined -> stale_frames = 3.
// - rst asserted in PENDING -> next cycle outputs 0, state IDLE; a later frame_start produces no commit.

Source files
------------

// File: rtl/sprite_frame_buffer.sv
// Double-buffered sprite position store: physics writes a shadow batch, frame_start commits it.
// Optional macro SPRITE_FRAME_STALE_CNT_EN builds the stale_frames counter.
module sprite_frame_buffer #(
    parameter int SPRITES = 4,
    parameter int IDX_W   = 2,
    parameter int MAX_ROW = 1199,
    parameter int MAX_COL = 1599
) (
    input  logic                      clock_162,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [IDX_W-1:0]          wr_index,
    input  logic [10:0]               wr_row,
    input  logic [11:0]               wr_col,
    input  logic                      wr_last,
    output logic [SPRITES-1:0][10:0]  sprite_row,
    output logic [SPRITES-1:0][11:0]  sprite_col,
    output logic                      commit_pulse,
    output logic [15:0]               frame_count,
    output logic                      idx_err,
    output logic [15:0]               stale_frames
);

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

    localparam logic [10:0] ROW_LIM = 11'(MAX_ROW);
    localparam logic [11:0] COL_LIM = 12'(MAX_COL);

    state_t state;
    state_t state_next;

    logic                     accept;
    logic                     idx_ok;
    logic                     close_batch;
    logic                     do_commit;
    logic [10:0]              row_clamped;
    logic [11:0]              col_clamped;
    logic [SPRITES-1:0][10:0] shadow_row;
    logic [SPRITES-1:0][11:0] shadow_col;

    assign accept      = wr_valid && wr_ready;
    assign idx_ok      = 32'(wr_index) < SPRITES;
    assign close_batch = accept && wr_last;
    assign do_commit   = (state == PENDING) && frame_start;
    assign row_clamped = (wr_row > ROW_LIM) ? ROW_LIM : wr_row;
    assign col_clamped = (wr_col > COL_LIM) ? COL_LIM : wr_col;

    always_ff @(posedge clock_162) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        wr_ready     = 1'b0;
        commit_pulse = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (close_batch) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit_pulse = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Out-of-range indices finish the handshake but only raise idx_err.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            shadow_row  <= '0;
            shadow_col  <= '0;
            sprite_row  <= '0;
            sprite_col  <= '0;
            frame_count <= '0;
            idx_err     <= 1'b0;
        end else begin
            for (int i = 0; i < SPRITES; i++) begin
                if (accept && idx_ok && (32'(wr_index) == i)) begin
                    shadow_row[i] <= row_clamped;
                    shadow_col[i] <= col_clamped;
                end
            end
            if (accept && !idx_ok) begin
                idx_err <= 1'b1;
            end
            if (do_commit) begin
                sprite_row  <= shadow_row;
                sprite_col  <= shadow_col;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef SPRITE_FRAME_STALE_CNT_EN
    // A frame_start that also closes the batch is not a stale frame.
    always_ff @(posedge clock_162) begin
        if (rst) begin
            stale_frames <= '0;
        end else if ((state == IDLE) && frame_start && !close_batch
                     && (stale_frames != 16'hFFFF)) begin
            stale_frames <= stale_frames + 16'd1;
        end
    end
`else
    assign stale_frames = '0;
`endif

endmodule

// File: tb/tb_sprite_frame_buffer.sv
// Directed self-checking bench for sprite_frame_buffer (SPRITES=4, IDX_W=3 so index 5 is expressible).
module tb_sprite_frame_buffer;

    logic                clock_162;
    logic                rst;
    logic                frame_start;
    logic                wr_valid;
    logic                wr_ready;
    logic [2:0]          wr_index;
    logic [10:0]         wr_row;
    logic [11:0]         wr_col;
    logic                wr_last;
    logic [3:0][10:0]    sprite_row;
    logic [3:0][11:0]    sprite_col;
    logic                commit_pulse;
    logic [15:0]         frame_count;
    logic                idx_err;
    logic [15:0]         stale_frames;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef SPRITE_FRAME_STALE_CNT_EN
    localparam int STALE_AFTER_3 = 3;
`else
    localparam int STALE_AFTER_3 = 0;
`endif

    sprite_frame_buffer #(
        .SPRITES(4),
        .IDX_W  (3),
        .MAX_ROW(1199),
        .MAX_COL(1599)
    ) dut (
        .clock_162   (clock_162),
        .rst         (rst),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_index    (wr_index),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_last     (wr_last),
        .sprite_row  (sprite_row),
        .sprite_col  (sprite_col),
        .commit_pulse(commit_pulse),
        .frame_count (frame_count),
        .idx_err     (idx_err),
        .stale_frames(stale_frames)
    );

    initial begin
        clock_162 = 1'b0;
        forever #5 clock_162 = ~clock_162;
    end

    task automatic tick();
        @(posedge clock_162);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic beat(input int idx, input int row, input int col, input logic last);
        wr_valid = 1'b1;
        wr_index = 3'(idx);
        wr_row   = 11'(row);
        wr_col   = 12'(col);
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_row"}, 32'(sprite_row[i]), 32'd0);
            check({tag, "_col"}, 32'(sprite_col[i]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        wr_valid = 1'b0;
        wr_index = '0;
        wr_row = '0;
        wr_col = '0;
        wr_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();

        // Reset state after idle cycles
        check_all_zero("reset");
        check("reset_ready", 32'(wr_ready), 32'd1);
        check("reset_pulse", 32'(commit_pulse), 32'd0);
        check("reset_fcount", 32'(frame_count), 32'd0);
        check("reset_idxerr", 32'(idx_err), 32'd0);
        check("reset_stale", 32'(stale_frames), 32'd0);

        // First batch; display must not change until one cycle after frame_start
        beat(0, 100, 200, 1'b0);
        beat(1, 300, 400, 1'b1);
        check("pend_ready", 32'(wr_ready), 32'd0);
        repeat (9) tick();
        frame_start = 1'b1;
        check("pre_commit_row0", 32'(sprite_row[0]), 32'd0);
        check("pre_commit_pulse", 32'(commit_pulse), 32'd0);
        tick();
        frame_start = 1'b0;
        check("c1_pulse", 32'(commit_pulse), 32'd1);
        check("c1_row0", 32'(sprite_row[0]), 32'd100);
        check("c1_col0", 32'(sprite_col[0]), 32'd200);
        check("c1_row1", 32'(sprite_row[1]), 32'd300);
        check("c1_col1", 32'(sprite_col[1]), 32'd400);
        check("c1_fcount", 32'(frame_count), 32'd1);
        check("c1_ready", 32'(wr_ready), 32'd0);
        tick();
        check("c1_pulse_end", 32'(commit_pulse), 32'd0);
        check("c1_ready_back", 32'(wr_ready), 32'd1);

        // Beats offered while PENDING are refused
        beat(2, 50, 60, 1'b1);
        wr_valid = 1'b1;
        wr_index = 3'd0;
        wr_row = 11'd7;
        wr_col = 12'd8;
        wr_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pend_block_ready", 32'(wr_ready), 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        wr_last = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("c2_pulse", 32'(commit_pulse), 32'd1);
        check("c2_row0_kept", 32'(sprite_row[0]), 32'd100);
        check("c2_col0_kept", 32'(sprite_col[0]), 32'd200);
        check("c2_row2", 32'(sprite_row[2]), 32'd50);
        check("c2_col2", 32'(sprite_col[2]), 32'd60);
        check("c2_fcount", 32'(frame_count), 32'd2);
        tick();
        check("c2_ready_n2", 32'(wr_ready), 32'd1);

        // Clamping, including values just past the limits
        beat(0, 1199, 1600, 1'b0);
        beat(3, 1500, 4000, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("clamp_row0_exact", 32'(sprite_row[0]), 32'd1199);
        check("clamp_col0", 32'(sprite_col[0]), 32'd1599);
        check("clamp_row3", 32'(sprite_row[3]), 32'd1199);
        check("clamp_col3", 32'(sprite_col[3]), 32'd1599);
        check("clamp_fcount", 32'(frame_count), 32'd3);
        tick();

        // Out-of-range index still closes the batch
        beat(5, 9, 9, 1'b1);
        check("idx5_err", 32'(idx_err), 32'd1);
        check("idx5_pending", 32'(wr_ready), 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("idx5_pulse", 32'(commit_pulse), 32'd1);
        check("idx5_row1", 32'(sprite_row[1]), 32'd300);
        check("idx5_row2", 32'(sprite_row[2]), 32'd50);
        check("idx5_row3", 32'(sprite_row[3]), 32'd1199);
        check("idx5_fcount", 32'(frame_count), 32'd4);
        tick();

        // frame_start coinciding with wr_last defers the commit to the next frame
        frame_start = 1'b1;
        beat(1, 11, 22, 1'b1);
        frame_start = 1'b0;
        check("same_pulse", 32'(commit_pulse), 32'd0);
        check("same_pending", 32'(wr_ready), 32'd0);
        check("same_row1", 32'(sprite_row[1]), 32'd300);
        check("same_stale", 32'(stale_frames), 32'd0);
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("same_c_pulse", 32'(commit_pulse), 32'd1);
        check("same_c_row1", 32'(sprite_row[1]), 32'd11);
        check("same_c_col1", 32'(sprite_col[1]), 32'd22);
        check("same_c_fcount", 32'(frame_count), 32'd5);
        tick();

        // Three frames with no batch ready
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("stale_no_pulse", 32'(commit_pulse), 32'd0);
            tick();
        end
        check("stale_count", 32'(stale_frames), 32'(STALE_AFTER_3));
        check("stale_fcount", 32'(frame_count), 32'd5);

        // Reset while PENDING discards everything
        beat(2, 77, 88, 1'b1);
        check("rst_pre_pending", 32'(wr_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("rst");
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_fcount", 32'(frame_count), 32'd0);
        check("rst_idxerr", 32'(idx_err), 32'd0);
        check("rst_stale", 32'(stale_frames), 32'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("rst_fs_pulse", 32'(commit_pulse), 32'd0);
        tick();
        check("rst_fs_pulse2", 32'(commit_pulse), 32'd0);
        check("rst_fs_row2", 32'(sprite_row[2]), 32'd0);
        check("rst_fs_fcount", 32'(frame_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
